// File: rtl/muldiv_sequencer.sv
// Iterative radix-2 multiply / restoring divide sequencer for the 2'b11 opcode class.
// Stalls the front end while iterating, then drives one (MUL/DIV/REM) or two (MULL) register writes.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       MdOp,
  input  logic             Unsigned,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [3:0]       RdLo,
  input  logic [3:0]       RdHi,
  input  logic             Flush,
  output logic             Stall,
  output logic             Busy,
  output logic             RegWE,
  output logic [3:0]       RegWA,
  output logic [WIDTH-1:0] RegWD,
  output logic             DivZero
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ITER  = 2'd1,
    S_WB_LO = 2'd2,
    S_WB_HI = 2'd3
  } state_t;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULL = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_REM  = 2'b11;

  state_t               r_state;
  logic [1:0]           r_op;
  logic                 r_neg;
  logic [3:0]           r_rd_lo;
  logic [3:0]           r_rd_hi;
  logic [CNTW-1:0]      r_cnt;
  logic [2*WIDTH-1:0]   r_p;
  logic [WIDTH-1:0]     r_b;
  logic                 r_busy;
  logic                 r_we;
  logic [3:0]           r_wa;
  logic [WIDTH-1:0]     r_wd;
  logic                 r_divzero;

  logic [WIDTH-1:0]     w_abs_a;
  logic [WIDTH-1:0]     w_abs_b;
  logic                 w_neg_start;
  logic                 w_div_zero;
  logic [WIDTH-1:0]     w_addend;
  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH-1:0]   w_mul_next;
  logic [WIDTH:0]       w_rem_sh;
  logic                 w_ge;
  logic [WIDTH-1:0]     w_rem_sub;
  logic [2*WIDTH-1:0]   w_div_next;
  logic [2*WIDTH-1:0]   w_p_next;
  logic [2*WIDTH-1:0]   w_p_fix;
  logic [WIDTH-1:0]     w_lo_data;
  logic                 w_last_iter;

  // Signed operands are iterated as magnitudes; the sign is restored at WB_LO entry.
  assign w_abs_a     = (!Unsigned && SrcA[WIDTH-1]) ? -SrcA : SrcA;
  assign w_abs_b     = (!Unsigned && SrcB[WIDTH-1]) ? -SrcB : SrcB;
  assign w_neg_start = !Unsigned &&
                       ((MdOp == OP_REM) ? SrcA[WIDTH-1] : (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]));
  assign w_div_zero  = MdOp[1] && (SrcB == '0);

  // Multiply step: conditional add into the upper half, carry shifts into the MSB.
  assign w_addend   = r_p[0] ? r_b : '0;
  assign w_mul_sum  = {1'b0, r_p[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
  assign w_mul_next = {w_mul_sum, r_p[WIDTH-1:1]};

  // Divide step: {R,Q} lives in r_p; the quotient bit enters at the bottom as Q is shifted out.
  assign w_rem_sh   = r_p[2*WIDTH-1:WIDTH-1];
  assign w_ge       = (w_rem_sh >= {1'b0, r_b});
  assign w_rem_sub  = w_rem_sh[WIDTH-1:0] - r_b;
  assign w_div_next = {(w_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0]), r_p[WIDTH-2:0], w_ge};

  assign w_p_next    = r_op[1] ? w_div_next : w_mul_next;
  assign w_last_iter = (r_cnt == {CNTW{1'b1}});

  always_comb begin
    w_p_fix = w_p_next;
    if (r_neg) begin
      case (r_op)
        OP_MUL, OP_MULL: w_p_fix = -w_p_next;
        OP_DIV:          w_p_fix[WIDTH-1:0] = -w_p_next[WIDTH-1:0];
        default:         w_p_fix[2*WIDTH-1:WIDTH] = -w_p_next[2*WIDTH-1:WIDTH];
      endcase
    end
  end

  assign w_lo_data = (r_op == OP_REM) ? w_p_fix[2*WIDTH-1:WIDTH] : w_p_fix[WIDTH-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_op      <= OP_MUL;
      r_neg     <= 1'b0;
      r_rd_lo   <= '0;
      r_rd_hi   <= '0;
      r_cnt     <= '0;
      r_p       <= '0;
      r_b       <= '0;
      r_busy    <= 1'b0;
      r_we      <= 1'b0;
      r_wa      <= '0;
      r_wd      <= '0;
      r_divzero <= 1'b0;
    end else begin
      r_we      <= 1'b0;
      r_divzero <= 1'b0;
      if (Flush) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (Start) begin
              r_op    <= MdOp;
              r_rd_lo <= RdLo;
              r_rd_hi <= RdHi;
              r_neg   <= w_neg_start;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              if (w_div_zero) begin
                r_state   <= S_WB_LO;
                r_we      <= 1'b1;
                r_wa      <= RdLo;
                r_wd      <= MdOp[0] ? SrcA : '1;
                r_divzero <= 1'b1;
              end else begin
                r_state <= S_ITER;
                if (MdOp[1]) begin
                  r_p <= {{WIDTH{1'b0}}, w_abs_a};
                  r_b <= w_abs_b;
                end else begin
                  r_p <= {{WIDTH{1'b0}}, w_abs_b};
                  r_b <= w_abs_a;
                end
              end
            end
          end
          S_ITER: begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last_iter) begin
              r_p     <= w_p_fix;
              r_state <= S_WB_LO;
              r_we    <= 1'b1;
              r_wa    <= r_rd_lo;
              r_wd    <= w_lo_data;
            end else begin
              r_p <= w_p_next;
            end
          end
          S_WB_LO: begin
            if (r_op == OP_MULL) begin
              r_state <= S_WB_HI;
              r_we    <= 1'b1;
              r_wa    <= r_rd_hi;
              r_wd    <= r_p[2*WIDTH-1:WIDTH];
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Stall releases in the final writeback cycle so the next instruction can issue behind it.
  assign Stall   = (Start && (r_state == S_IDLE)) || (r_state == S_ITER) ||
                   ((r_state == S_WB_LO) && (r_op == OP_MULL));
  assign Busy    = r_busy;
  assign RegWE   = r_we;
  assign RegWA   = r_wa;
  assign RegWD   = r_wd;
  assign DivZero = r_divzero;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed table, randomized ops against an arithmetic model,
// and hand-written flush / busy-start / async-reset sequences.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0;
  logic [1:0]  MdOp = 2'b00;
  logic        Unsigned = 1'b0;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic [3:0]  RdLo = '0;
  logic [3:0]  RdHi = '0;
  logic        Flush = 1'b0;
  logic        Stall;
  logic        Busy;
  logic        RegWE;
  logic [3:0]  RegWA;
  logic [31:0] RegWD;
  logic        DivZero;

  int n_tests = 0;
  int n_fail  = 0;

  muldiv_sequencer #(.WIDTH(32), .CNTW(5)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MdOp(MdOp), .Unsigned(Unsigned),
    .SrcA(SrcA), .SrcB(SrcB), .RdLo(RdLo), .RdHi(RdHi), .Flush(Flush),
    .Stall(Stall), .Busy(Busy), .RegWE(RegWE), .RegWA(RegWA), .RegWD(RegWD),
    .DivZero(DivZero)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  op;
    logic        uns;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  rlo;
    logic [3:0]  rhi;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
  } vec_t;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Plain-arithmetic reference: 64-bit products, truncating signed division.
  function automatic void model(input logic [1:0] op, input logic uns, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] lo,
                                output logic [31:0] hi, output logic dz);
    longint      sa, sb, q, r;
    logic [63:0] p;
    dz = 1'b0;
    hi = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op[1] && b == 32'h0) begin
      dz = 1'b1;
      lo = op[0] ? a : 32'hFFFF_FFFF;
    end else if (!op[1]) begin
      if (uns) p = {32'h0, a} * {32'h0, b};
      else     p = sa * sb;
      lo = p[31:0];
      hi = p[63:32];
    end else if (uns) begin
      lo = op[0] ? (a % b) : (a / b);
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      lo = op[0] ? r[31:0] : q[31:0];
    end
  endfunction

  task automatic idle_watch(input int n, output int we_cnt, output int busy_cnt, output int dz_cnt);
    we_cnt = 0;
    busy_cnt = 0;
    dz_cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      Start = 1'b0;
      Flush = 1'b0;
      #1;
      if (RegWE)   we_cnt++;
      if (Busy)    busy_cnt++;
      if (DivZero) dz_cnt++;
    end
  endtask

  // One full operation: pulse Start, watch 40 cycles, then compare timing and written values.
  task automatic do_op(input logic [1:0] op, input logic uns, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] rlo, input logic [3:0] rhi,
                       input logic [31:0] elo, input logic [31:0] ehi, input logic edz);
    int n_wr, k0, k1, n_stall, n_busy, n_dz, k_dz, lat, nexp;
    logic [3:0]  a0, a1;
    logic [31:0] d0, d1;
    n_wr = 0; k0 = -1; k1 = -1; n_stall = 0; n_busy = 0; n_dz = 0; k_dz = -1;
    a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    @(negedge clk);
    MdOp = op; Unsigned = uns; SrcA = a; SrcB = b; RdLo = rlo; RdHi = rhi; Start = 1'b1;
    #1;
    if (Stall) n_stall++;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      Start = 1'b0;
      MdOp = 2'($urandom_range(0, 3)); Unsigned = 1'($urandom_range(0, 1));
      SrcA = $urandom; SrcB = $urandom; RdLo = 4'($urandom_range(0, 15)); RdHi = 4'($urandom_range(0, 15));
      #1;
      if (Stall) n_stall++;
      if (Busy)  n_busy++;
      if (DivZero) begin
        n_dz++;
        k_dz = k;
      end
      if (RegWE) begin
        if (n_wr == 0) begin
          k0 = k; a0 = RegWA; d0 = RegWD;
        end else if (n_wr == 1) begin
          k1 = k; a1 = RegWA; d1 = RegWD;
        end
        n_wr++;
      end
    end
    lat  = edz ? 1 : 33;
    nexp = (op == 2'b01) ? 2 : 1;
    $display("[TB] txn op=%0d uns=%0d a=%h b=%h -> writes=%0d wa0=%h wd0=%h wd1=%h dz=%0d",
             op, uns, a, b, n_wr, a0, d0, d1, n_dz);
    checki("write count", n_wr, nexp);
    checki("first write cycle", k0, lat);
    check32("lo write addr", 32'(a0), 32'(rlo));
    check32("lo write data", d0, elo);
    if (nexp == 2) begin
      checki("hi write cycle", k1, lat + 1);
      check32("hi write addr", 32'(a1), 32'(rhi));
      check32("hi write data", d1, ehi);
    end
    checki("stall cycles", n_stall, lat + nexp - 1);
    checki("busy cycles", n_busy, lat + nexp - 1);
    checki("divzero pulses", n_dz, 32'(edz));
    if (edz) checki("divzero cycle", k_dz, 1);
    check32("held addr", 32'(RegWA), 32'((nexp == 2) ? rhi : rlo));
    check32("held data", RegWD, (nexp == 2) ? ehi : elo);
  endtask

  vec_t vecs[15];

  initial begin
    int we_c, busy_c, dz_c;
    logic [1:0]  r_op;
    logic        r_uns;
    logic [31:0] r_a, r_b, m_lo, m_hi;
    logic        m_dz;

    vecs[0]  = '{2'b00, 1'b1, 32'h0001_0000, 32'h0001_0000, 4'h1, 4'h2, 32'h0000_0000, 32'h0, 1'b0};
    vecs[1]  = '{2'b01, 1'b0, 32'hFFFF_FFFD, 32'h0000_0007, 4'h3, 4'h4, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0};
    vecs[2]  = '{2'b10, 1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 4'h5, 4'h0, 32'hFFFF_FFFD, 32'h0, 1'b0};
    vecs[3]  = '{2'b11, 1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 4'h6, 4'h0, 32'hFFFF_FFFF, 32'h0, 1'b0};
    vecs[4]  = '{2'b10, 1'b1, 32'd100, 32'd7, 4'h7, 4'h0, 32'd14, 32'h0, 1'b0};
    vecs[5]  = '{2'b11, 1'b1, 32'd100, 32'd7, 4'h8, 4'h0, 32'd2, 32'h0, 1'b0};
    vecs[6]  = '{2'b10, 1'b0, 32'h1234_5678, 32'h0, 4'h9, 4'h0, 32'hFFFF_FFFF, 32'h0, 1'b1};
    vecs[7]  = '{2'b11, 1'b1, 32'd9, 32'h0, 4'hA, 4'h0, 32'd9, 32'h0, 1'b1};
    vecs[8]  = '{2'b10, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 4'hB, 4'h0, 32'h8000_0000, 32'h0, 1'b0};
    vecs[9]  = '{2'b11, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 4'hC, 4'h0, 32'h0, 32'h0, 1'b0};
    vecs[10] = '{2'b01, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hD, 4'hE, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0};
    vecs[11] = '{2'b01, 1'b0, 32'h8000_0000, 32'h8000_0000, 4'hF, 4'hF, 32'h0, 32'h4000_0000, 1'b0};
    vecs[12] = '{2'b11, 1'b0, 32'd7, 32'hFFFF_FFFE, 4'h1, 4'h0, 32'd1, 32'h0, 1'b0};
    vecs[13] = '{2'b11, 1'b0, 32'hFFFF_FFF9, 32'h0, 4'h2, 4'h0, 32'hFFFF_FFF9, 32'h0, 1'b1};
    vecs[14] = '{2'b00, 1'b0, 32'hFFFF_FFFD, 32'h0000_0007, 4'h3, 4'h0, 32'hFFFF_FFEB, 32'h0, 1'b0};

    // Reset values
    #2 reset = 1'b0;
    #1;
    check32("reset Busy", 32'(Busy), 32'd0);
    check32("reset RegWE", 32'(RegWE), 32'd0);
    check32("reset RegWA", 32'(RegWA), 32'd0);
    check32("reset RegWD", RegWD, 32'd0);
    check32("reset DivZero", 32'(DivZero), 32'd0);
    check32("reset Stall", 32'(Stall), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i])
      do_op(vecs[i].op, vecs[i].uns, vecs[i].a, vecs[i].b, vecs[i].rlo, vecs[i].rhi,
            vecs[i].lo, vecs[i].hi, vecs[i].dz);

    for (int i = 0; i < 40; i++) begin
      r_op  = 2'($urandom_range(0, 3));
      r_uns = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: r_a = 32'h8000_0000;
        1: r_a = 32'hFFFF_FFFF;
        2: r_a = 32'($urandom_range(0, 20));
        default: r_a = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0: r_b = 32'h0;
        1: r_b = 32'hFFFF_FFFF;
        2: r_b = 32'($urandom_range(1, 20));
        3: r_b = 32'h8000_0000;
        default: r_b = $urandom;
      endcase
      model(r_op, r_uns, r_a, r_b, m_lo, m_hi, m_dz);
      do_op(r_op, r_uns, r_a, r_b, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            m_lo, m_hi, m_dz);
    end

    // Flush during iteration 10 of a MUL
    @(negedge clk);
    MdOp = 2'b00; Unsigned = 1'b1; SrcA = 32'd5; SrcB = 32'd6; RdLo = 4'h3; Start = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      Start = 1'b0;
      Flush = (k == 11);
      #1;
    end
    check32("busy before iter flush", 32'(Busy), 32'd1);
    @(negedge clk);
    Flush = 1'b0;
    #1;
    check32("busy after iter flush", 32'(Busy), 32'd0);
    check32("stall after iter flush", 32'(Stall), 32'd0);
    check32("we after iter flush", 32'(RegWE), 32'd0);
    idle_watch(40, we_c, busy_c, dz_c);
    checki("writes after iter flush", we_c, 0);
    $display("[TB] txn flush at iteration 10 -> later writes=%0d", we_c);

    // Flush in the WB_LO cycle of a MULL: low write lands, high write is suppressed
    @(negedge clk);
    MdOp = 2'b01; Unsigned = 1'b0; SrcA = 32'd3; SrcB = 32'hFFFF_FFFB; RdLo = 4'h2; RdHi = 4'h4;
    Start = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      Start = 1'b0;
      Flush = (k == 33);
      #1;
    end
    check32("wb_lo we before flush", 32'(RegWE), 32'd1);
    check32("wb_lo data before flush", RegWD, 32'hFFFF_FFF1);
    @(negedge clk);
    Flush = 1'b0;
    #1;
    check32("we after wb_lo flush", 32'(RegWE), 32'd0);
    check32("busy after wb_lo flush", 32'(Busy), 32'd0);
    idle_watch(10, we_c, busy_c, dz_c);
    checki("writes after wb_lo flush", we_c, 0);
    check32("addr after wb_lo flush", 32'(RegWA), 32'h2);
    $display("[TB] txn flush in MULL WB_LO -> later writes=%0d wa=%h", we_c, RegWA);

    // Flush together with Start in IDLE: nothing starts, even a divide by zero
    @(negedge clk);
    MdOp = 2'b10; Unsigned = 1'b1; SrcA = 32'd9; SrcB = 32'h0; RdLo = 4'h5; Start = 1'b1; Flush = 1'b1;
    idle_watch(40, we_c, busy_c, dz_c);
    checki("flush+start writes", we_c, 0);
    checki("flush+start busy", busy_c, 0);
    checki("flush+start divzero", dz_c, 0);
    $display("[TB] txn flush with start -> writes=%0d busy=%0d dz=%0d", we_c, busy_c, dz_c);

    // Start while busy is ignored
    @(negedge clk);
    MdOp = 2'b00; Unsigned = 1'b1; SrcA = 32'd3; SrcB = 32'd5; RdLo = 4'h1; Start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      Start = (k == 5);
      if (k == 5) begin
        MdOp = 2'b10; SrcB = 32'h0; RdLo = 4'h9;
      end
    end
    idle_watch(45, we_c, busy_c, dz_c);
    checki("busy-start writes", we_c, 1);
    checki("busy-start divzero", dz_c, 0);
    check32("busy-start addr", 32'(RegWA), 32'h1);
    check32("busy-start data", RegWD, 32'd15);
    $display("[TB] txn start while busy -> writes=%0d wa=%h wd=%h", we_c, RegWA, RegWD);

    // Asynchronous reset mid-ITER
    @(negedge clk);
    MdOp = 2'b00; Unsigned = 1'b1; SrcA = 32'd11; SrcB = 32'd13; RdLo = 4'h7; Start = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      Start = 1'b0;
    end
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check32("async reset Busy", 32'(Busy), 32'd0);
    check32("async reset RegWE", 32'(RegWE), 32'd0);
    check32("async reset Stall", 32'(Stall), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    idle_watch(40, we_c, busy_c, dz_c);
    checki("writes after async reset", we_c, 0);
    checki("busy after async reset", busy_c, 0);
    $display("[TB] txn async reset mid-ITER -> writes=%0d busy=%0d", we_c, busy_c);
    do_op(2'b00, 1'b1, 32'd6, 32'd7, 4'h6, 4'h0, 32'd42, 32'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multicycle sequencer for the Op=2'b11 multiply/divide instructions. Once decode has produced Unsigned, Long and the operation class, this block runs an iterative radix-2 multiply or divide over 32 cycles.
- While it runs it stalls the front of the pipeline, then drives the register-file write port: one result for MUL/DIV, two results (RdLo, then RdHi) for long multiplies.
- Sits beside the ALU. Its write port is muxed ahead of the normal writeback path.

Parameters:
- WIDTH, 32, operand and result-half width.
- CNTW, 5, iteration-counter width; must satisfy 2^CNTW = WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- Start  input  1  one-cycle request; sampled only in IDLE.
- MdOp  input  2  00 MUL (low half), 01 MULL (long), 10 DIV (quotient), 11 REM (remainder).
- Unsigned  input  1  1 = unsigned operands, 0 = two's-complement.
- SrcA  input  WIDTH  multiplicand or dividend.
- SrcB  input  WIDTH  multiplier or divisor.
- RdLo  input  4  destination for the low result (or only result).
- RdHi  input  4  destination for the high result (MULL only).
- Flush  input  1  abort the current operation with no writeback.
- Stall  output  1  holds fetch/decode; combinational.
- Busy  output  1  registered; high in any non-IDLE state.
- RegWE  output  1  register-file write enable, registered.
- RegWA  output  4  write address, registered.
- RegWD  output  WIDTH  write data, registered.
- DivZero  output  1  one-cycle pulse when a divide by zero is detected.

Behaviour:
- Reset (reset=0, asynchronous):
  - State = IDLE.
  - Busy, RegWE, DivZero = 0; RegWA = 0; RegWD = 0.
  - Counter, accumulator and operand registers are cleared.
  - Reset mid-operation discards all work and produces no writeback.
- States: IDLE, ITER, WB_LO, WB_HI.
- IDLE:
  - On Start, latch MdOp, Unsigned, RdLo and RdHi.
  - If signed, store |SrcA| and |SrcB| and latch NegRes. For MUL/MULL/DIV, NegRes = SrcA[31]^SrcB[31]. For REM, NegRes = SrcA[31].
  - Counter = 0, then go to ITER.
  - Divide by zero (MdOp[1]=1, SrcB=0): skip ITER and go to WB_LO, pulse DivZero. DIV result = all ones; REM result = SrcA unmodified.
- ITER, one iteration per cycle, 32 cycles (counter 0..31):
  - Multiply: 64-bit product P. If multiplier bit0 = 1, add the multiplicand into the upper half; then shift P right by 1, with the adder carry entering bit 63.
  - Divide: restoring. Shift {R,Q} left by 1; if R >= divisor, then R -= divisor and Q[0] = 1.
  - After counter = 31, go to WB_LO.
- Sign fix-up is applied at WB_LO entry when signed and NegRes = 1:
  - MUL/MULL: negate the 64-bit product.
  - DIV: negate Q.
  - REM: negate R.
  - INT_MIN/-1 yields quotient 0x80000000 and remainder 0; this is not flagged.
- WB_LO, one cycle:
  - RegWE = 1, RegWA = RdLo.
  - RegWD = P[31:0], Q or R, according to MdOp.
  - Next state is WB_HI if MdOp = MULL, else IDLE.
- WB_HI, one cycle: RegWE = 1, RegWA = RdHi, RegWD = P[63:32]; next state IDLE.
- Stall = (Start & state==IDLE) | (state==ITER) | (state==WB_LO & MdOp==MULL). Stall drops in the final writeback cycle so the next instruction issues one cycle later.
- Latency from the Start cycle to the first RegWE cycle: 33 cycles, or 1 cycle for a divide by zero. MULL takes one additional write cycle.
- Start while not IDLE is ignored and does not queue.
- Flush:
  - In any state it forces IDLE on the next edge.
  - The RegWE that would have asserted on that edge is suppressed.
  - Flush together with Start in IDLE: Flush wins and nothing starts.
- RdLo == RdHi on MULL: both writes occur in order, so the high half wins.
- RegWE is 0 in every cycle not listed above. RegWA and RegWD hold their last values when RegWE = 0.

Test Plan:
1. Unsigned MUL 0x0001_0000 × 0x0001_0000 → after 33 cycles one write: RegWA=RdLo, RegWD=0x0000_0000. Stall high for 33 cycles.
2. Signed MULL −3 × 7 (0xFFFF_FFFD, 0x7) → write RdLo=0xFFFF_FFEB, then next cycle RdHi=0xFFFF_FFFF. Busy high for 34 cycles.
3. Signed DIV −7/2 → quotient 0xFFFF_FFFD. Signed REM −7/2 → remainder 0xFFFF_FFFF. Unsigned DIV 100/7 → 14, REM → 2.
4. DIV with SrcB=0 → DivZero pulse, and one cycle after Start a write of 0xFFFF_FFFF. REM 9/0 → writes 9. No ITER cycles.
5. Flush asserted at iteration 10, and separately in the WB_LO cycle of a MULL → no RegWE, back in IDLE next cycle. A Start pulsed while busy produces no second operation.
6. reset driven low asynchronously mid-ITER (between clock edges) → Busy, RegWE and Stall fall immediately. After release, a fresh MUL 6×7 writes 42 after 33 cycles.
